// File: rtl/prach_acc.sv
// PRACH correlation accumulator: sums a frame of signed products, then rounds,
// shifts and saturates the total into a single output sample per frame.
//
// Ports:
//   clk, rst      rising-edge clock, synchronous active-high reset
//   start, len    arm a new frame of len samples (len = 0 arms nothing)
//   in_valid      qualifies in_data / in_ovf
//   in_data       signed product sample from the multiplier stage
//   in_ovf        multiplier overflow flag aligned with in_data
//   out_valid     one-cycle pulse when a frame completes
//   out_data      rounded, saturated frame sum (held between pulses)
//   out_ovf       OR of accepted in_ovf over the frame (held)
//   out_sat       frame result was clamped (held)
//   busy          frame in progress
module prach_acc #(
    parameter int IN_WIDTH  = 16,
    parameter int ACC_WIDTH = 32,
    parameter int LEN_WIDTH = 12,
    parameter int OUT_WIDTH = 16,
    parameter int SHIFT     = 12
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [LEN_WIDTH-1:0]        len,
    input  logic                        in_valid,
    input  logic signed [IN_WIDTH-1:0]  in_data,
    input  logic                        in_ovf,
    output logic                        out_valid,
    output logic signed [OUT_WIDTH-1:0] out_data,
    output logic                        out_ovf,
    output logic                        out_sat,
    output logic                        busy
);

    // One guard bit above ACC_WIDTH so the rounding add can never wrap.
    localparam int AW = ACC_WIDTH + 1;

    localparam logic signed [OUT_WIDTH-1:0] OUT_MAX =
        {1'b0, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [OUT_WIDTH-1:0] OUT_MIN =
        {1'b1, {(OUT_WIDTH-1){1'b0}}};

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        ACC  = 1'b1
    } state_t;

    state_t state;
    state_t state_nxt;

    logic signed [AW-1:0]        acc;
    logic signed [AW-1:0]        in_ext;
    logic signed [AW-1:0]        sum;
    logic signed [AW-1:0]        rounded;
    logic signed [AW-1:0]        shifted;
    logic signed [OUT_WIDTH-1:0] sat_val;
    logic [LEN_WIDTH-1:0]        cnt;
    logic [LEN_WIDTH-1:0]        cnt_inc;
    logic [LEN_WIDTH-1:0]        len_q;
    logic                        ovf_sticky;
    logic                        ovf_nxt;
    logic                        arm;
    logic                        accept;
    logic                        last;
    logic                        sat_hi;
    logic                        sat_lo;

    // ------------------------------------------------------------------
    // Datapath: final sum is formed combinationally from the sample being
    // accepted, so the result registers on the same edge as the last sample.
    // ------------------------------------------------------------------
    assign in_ext  = {{(AW-IN_WIDTH){in_data[IN_WIDTH-1]}}, in_data};
    assign sum     = acc + in_ext;
    assign ovf_nxt = ovf_sticky | in_ovf;

    generate
        if (SHIFT > 0) begin : g_round
            localparam logic signed [AW-1:0] HALF = AW'(1) << (SHIFT - 1);
            assign rounded = sum + HALF;
        end else begin : g_no_round
            assign rounded = sum;
        end
    endgenerate

    assign shifted = rounded >>> SHIFT;

    // The value fits OUT_WIDTH only when every bit from the output sign bit
    // upward matches the true sign.
    assign sat_hi = !shifted[AW-1] && (|shifted[AW-2:OUT_WIDTH-1]);
    assign sat_lo =  shifted[AW-1] && !(&shifted[AW-2:OUT_WIDTH-1]);

    always_comb begin
        sat_val = shifted[OUT_WIDTH-1:0];
        if (sat_hi) begin
            sat_val = OUT_MAX;
        end else if (sat_lo) begin
            sat_val = OUT_MIN;
        end
    end

    // ------------------------------------------------------------------
    // Control: start always wins over a coincident sample, which also
    // covers the abort and last-sample collision cases.
    // ------------------------------------------------------------------
    assign arm     = start && (len != '0);
    assign accept  = (state == ACC) && in_valid && !start;
    assign cnt_inc = cnt + LEN_WIDTH'(1);
    assign last    = accept && (cnt_inc == len_q);
    assign busy    = (state == ACC);

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (arm) begin
                    state_nxt = ACC;
                end
            end
            ACC: begin
                if (start) begin
                    state_nxt = arm ? ACC : IDLE;
                end else if (last) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            acc        <= '0;
            cnt        <= '0;
            len_q      <= '0;
            ovf_sticky <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_ovf    <= 1'b0;
            out_sat    <= 1'b0;
        end else begin
            state     <= state_nxt;
            out_valid <= 1'b0;
            if (arm) begin
                acc        <= '0;
                cnt        <= '0;
                len_q      <= len;
                ovf_sticky <= 1'b0;
            end else if (accept) begin
                acc        <= sum;
                cnt        <= cnt_inc;
                ovf_sticky <= ovf_nxt;
                if (last) begin
                    out_valid <= 1'b1;
                    out_data  <= sat_val;
                    out_ovf   <= ovf_nxt;
                    out_sat   <= sat_hi | sat_lo;
                end
            end
        end
    end

endmodule

// File: tb/tb_prach_acc.sv
// Self-checking bench for prach_acc: three instances (SHIFT 12, 4, 0) share
// one stimulus stream and are compared against an arithmetic frame model.
module tb_prach_acc;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [11:0] len = '0;
    logic        in_valid = 1'b0;
    logic signed [15:0] in_data = '0;
    logic        in_ovf = 1'b0;

    logic               ov [3];
    logic signed [15:0] od [3];
    logic               oo [3];
    logic               os [3];
    logic               bz [3];

    int total = 0;
    int bad = 0;
    int npulse = 0;

    int q_data[$];
    bit q_ovf[$];

    bit                 r_early;
    logic               r_v [3];
    logic signed [15:0] r_d [3];
    logic               r_ovf [3];
    logic               r_sat [3];
    logic               r_busy [3];
    logic               r_v2 [3];
    logic signed [15:0] r_d2 [3];

    always #5 clk = ~clk;

    always @(negedge clk) if (ov[0] === 1'b1) npulse++;

    prach_acc #(.SHIFT(12)) u_s12 (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .in_valid(in_valid), .in_data(in_data), .in_ovf(in_ovf),
        .out_valid(ov[0]), .out_data(od[0]), .out_ovf(oo[0]),
        .out_sat(os[0]), .busy(bz[0]));

    prach_acc #(.SHIFT(4)) u_s4 (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .in_valid(in_valid), .in_data(in_data), .in_ovf(in_ovf),
        .out_valid(ov[1]), .out_data(od[1]), .out_ovf(oo[1]),
        .out_sat(os[1]), .busy(bz[1]));

    prach_acc #(.SHIFT(0)) u_s0 (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .in_valid(in_valid), .in_data(in_data), .in_ovf(in_ovf),
        .out_valid(ov[2]), .out_data(od[2]), .out_ovf(oo[2]),
        .out_sat(os[2]), .busy(bz[2]));

    function automatic int shift_of(input int k);
        return (k == 0) ? 12 : (k == 1) ? 4 : 0;
    endfunction

    // Frame result straight from the arithmetic rules: exact sum, add half
    // an LSB, floor-divide by 2^sh, clamp to 16-bit signed.
    function automatic void model(input int sh,
                                  output logic signed [15:0] d,
                                  output logic s);
        longint a = 0;
        foreach (q_data[i]) a += q_data[i];
        if (sh > 0) a += (64'sd1 <<< (sh - 1));
        a = a >>> sh;
        s = 1'b1;
        if (a > 32767) d = 16'sh7fff;
        else if (a < -32768) d = 16'sh8000;
        else begin
            d = 16'(a);
            s = 1'b0;
        end
    endfunction

    function automatic logic model_ovf();
        logic o = 1'b0;
        foreach (q_ovf[i]) o |= q_ovf[i];
        return o;
    endfunction

    task automatic cyc(input bit st, input int ln, input bit iv,
                       input int d, input bit o);
        start = st;
        len = ln[11:0];
        in_valid = iv;
        in_data = d[15:0];
        in_ovf = o;
        @(posedge clk);
        #1;
    endtask

    task automatic grab(input bit second);
        for (int k = 0; k < 3; k++) begin
            if (!second) begin
                r_v[k] = ov[k];
                r_d[k] = od[k];
                r_ovf[k] = oo[k];
                r_sat[k] = os[k];
                r_busy[k] = bz[k];
            end else begin
                r_v2[k] = ov[k];
                r_d2[k] = od[k];
            end
        end
    endtask

    // Plays q_data/q_ovf as one frame. gapmax < 0 inserts exactly one idle
    // cycle between samples; otherwise gaps are random up to gapmax.
    task automatic run_frame(input int gapmax, input bit coll);
        int n = q_data.size();
        int g;
        r_early = 1'b0;
        cyc(1, n, coll, 30000, coll);
        for (int i = 0; i < n; i++) begin
            g = (gapmax < 0) ? ((i > 0) ? 1 : 0) : $urandom_range(gapmax, 0);
            repeat (g) begin
                cyc(0, 0, 0, -12345, 1);
                if (ov[0] | ov[1] | ov[2]) r_early = 1'b1;
            end
            cyc(0, 0, 1, q_data[i], q_ovf[i]);
            if (i < n - 1 && (ov[0] | ov[1] | ov[2])) r_early = 1'b1;
        end
        grab(0);
        cyc(0, 0, 0, 0, 0);
        grab(1);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc(1, 5, 1, 1234, 1);
        cyc(1, 5, 1, 1234, 1);
        for (int k = 0; k < 3; k++) begin
            total++;
            if ({ov[k], od[k], oo[k], os[k], bz[k]} !== 20'd0) begin
                bad++;
                $display("FAIL reset[%0d]: v=%b d=%0d ovf=%b sat=%b busy=%b, want all 0",
                         k, ov[k], od[k], oo[k], os[k], bz[k]);
            end
        end
        rst = 1'b0;
        cyc(0, 0, 0, 0, 0);
    endtask

    task automatic test_basic();
        logic signed [15:0] ed;
        logic es;
        q_data = '{1000, 2000, -500, 3596};
        q_ovf = '{0, 0, 0, 0};
        run_frame(0, 0);
        total++;
        if (r_d[0] !== 16'sd1) begin
            bad++;
            $display("FAIL basic_const: got %0d want 1", r_d[0]);
        end
        for (int k = 0; k < 3; k++) begin
            model(shift_of(k), ed, es);
            total++;
            if ({r_early, r_v[k], r_d[k], r_ovf[k], r_sat[k], r_busy[k]} !==
                {1'b0, 1'b1, ed, 1'b0, es, 1'b0}) begin
                bad++;
                $display("FAIL basic[%0d]: early=%b v=%b d=%0d ovf=%b sat=%b busy=%b want v=1 d=%0d sat=%b",
                         k, r_early, r_v[k], r_d[k], r_ovf[k], r_sat[k], r_busy[k], ed, es);
            end
            total++;
            if ({r_v2[k], r_d2[k]} !== {1'b0, ed}) begin
                bad++;
                $display("FAIL basic_hold[%0d]: v=%b d=%0d want v=0 d=%0d", k, r_v2[k], r_d2[k], ed);
            end
        end
    endtask

    task automatic test_gaps_ovf();
        logic signed [15:0] ed;
        logic es;
        q_data = '{4096, 4096, 4096};
        q_ovf = '{0, 1, 0};
        run_frame(-1, 0);
        total++;
        if ({r_d[0], r_ovf[0]} !== {16'sd3, 1'b1}) begin
            bad++;
            $display("FAIL gaps_const: got d=%0d ovf=%b want d=3 ovf=1", r_d[0], r_ovf[0]);
        end
        for (int k = 0; k < 3; k++) begin
            model(shift_of(k), ed, es);
            total++;
            if ({r_early, r_v[k], r_d[k], r_ovf[k], r_sat[k], r_busy[k], r_v2[k]} !==
                {1'b0, 1'b1, ed, 1'b1, es, 1'b0, 1'b0}) begin
                bad++;
                $display("FAIL gaps[%0d]: early=%b v=%b d=%0d ovf=%b sat=%b busy=%b v2=%b want d=%0d ovf=1 sat=%b",
                         k, r_early, r_v[k], r_d[k], r_ovf[k], r_sat[k], r_busy[k], r_v2[k], ed, es);
            end
        end
    endtask

    task automatic test_saturation();
        logic signed [15:0] ed;
        logic es;
        int val [2] = '{32767, -32768};
        for (int f = 0; f < 2; f++) begin
            q_data = {};
            q_ovf = {};
            repeat (4095) begin
                q_data.push_back(val[f]);
                q_ovf.push_back(1'b0);
            end
            run_frame(0, 0);
            for (int k = 0; k < 3; k++) begin
                model(shift_of(k), ed, es);
                total++;
                if ({r_v[k], r_d[k], r_sat[k], r_v2[k]} !== {1'b1, ed, es, 1'b0}) begin
                    bad++;
                    $display("FAIL sat%0d[%0d]: v=%b d=%0d sat=%b v2=%b want d=%0d sat=%b",
                             f, k, r_v[k], r_d[k], r_sat[k], r_v2[k], ed, es);
                end
            end
        end
    endtask

    task automatic test_rounding();
        int val [2] = '{-2048, -2049};
        logic signed [15:0] want [2] = '{16'sd0, -16'sd1};
        for (int f = 0; f < 2; f++) begin
            q_data = '{val[f]};
            q_ovf = '{0};
            run_frame(0, 0);
            total++;
            if ({r_v[0], r_d[0], r_sat[0]} !== {1'b1, want[f], 1'b0}) begin
                bad++;
                $display("FAIL round%0d: v=%b d=%0d sat=%b want v=1 d=%0d sat=0",
                         f, r_v[0], r_d[0], r_sat[0], want[f]);
            end
        end
    endtask

    task automatic test_abort();
        logic signed [15:0] ed;
        logic es;
        int p0;
        p0 = npulse;
        cyc(1, 5, 0, 0, 0);
        cyc(0, 0, 1, 100, 1);
        cyc(0, 0, 1, 200, 0);
        cyc(1, 3, 1, 999, 1);
        cyc(0, 0, 1, 5000, 0);
        cyc(0, 0, 1, 7000, 0);
        cyc(0, 0, 1, -1000, 0);
        grab(0);
        q_data = '{5000, 7000, -1000};
        q_ovf = '{0, 0, 0};
        for (int k = 0; k < 3; k++) begin
            model(shift_of(k), ed, es);
            total++;
            if ({r_v[k], r_d[k], r_ovf[k], r_sat[k]} !== {1'b1, ed, 1'b0, es}) begin
                bad++;
                $display("FAIL abort[%0d]: v=%b d=%0d ovf=%b sat=%b want v=1 d=%0d ovf=0 sat=%b",
                         k, r_v[k], r_d[k], r_ovf[k], r_sat[k], ed, es);
            end
        end
        cyc(0, 0, 0, 0, 0);
        total++;
        if (npulse !== p0 + 1) begin
            bad++;
            $display("FAIL abort_pulses: got %0d want %0d", npulse - p0, 1);
        end
        p0 = npulse;
        cyc(1, 2, 0, 0, 0);
        cyc(0, 0, 1, 3000, 0);
        cyc(1, 2, 1, 4000, 1);
        cyc(0, 0, 0, 0, 0);
        total++;
        if ({npulse == p0, bz[0]} !== 2'b11) begin
            bad++;
            $display("FAIL collide_nopulse: pulses=%0d busy=%b want 0 and 1", npulse - p0, bz[0]);
        end
        cyc(0, 0, 1, -7000, 0);
        cyc(0, 0, 1, 9000, 0);
        grab(0);
        q_data = '{-7000, 9000};
        q_ovf = '{0, 0};
        for (int k = 0; k < 3; k++) begin
            model(shift_of(k), ed, es);
            total++;
            if ({r_v[k], r_d[k], r_ovf[k], r_sat[k]} !== {1'b1, ed, 1'b0, es}) begin
                bad++;
                $display("FAIL collide[%0d]: v=%b d=%0d ovf=%b sat=%b want v=1 d=%0d ovf=0 sat=%b",
                         k, r_v[k], r_d[k], r_ovf[k], r_sat[k], ed, es);
            end
        end
        cyc(0, 0, 0, 0, 0);
    endtask

    task automatic test_idle();
        logic signed [15:0] ed;
        logic es;
        int p0;
        p0 = npulse;
        repeat (3) cyc(0, 0, 1, 5555, 1);
        cyc(1, 0, 1, 5555, 1);
        cyc(0, 0, 1, 5555, 1);
        total++;
        if ({npulse == p0, bz[0], bz[1], bz[2]} !== 4'b1000) begin
            bad++;
            $display("FAIL idle_ignore: pulses=%0d busy=%b%b%b want 0 and 000",
                     npulse - p0, bz[0], bz[1], bz[2]);
        end
        q_data = '{1000, 2000};
        q_ovf = '{0, 0};
        run_frame(0, 1);
        for (int k = 0; k < 3; k++) begin
            model(shift_of(k), ed, es);
            total++;
            if ({r_v[k], r_d[k], r_ovf[k], r_sat[k]} !== {1'b1, ed, 1'b0, es}) begin
                bad++;
                $display("FAIL idle_coll[%0d]: v=%b d=%0d ovf=%b sat=%b want v=1 d=%0d ovf=0 sat=%b",
                         k, r_v[k], r_d[k], r_ovf[k], r_sat[k], ed, es);
            end
        end
    endtask

    task automatic test_reset_mid();
        int p0;
        q_data = '{20000, 1};
        q_ovf = '{1, 0};
        run_frame(0, 0);
        cyc(1, 8, 0, 0, 0);
        repeat (3) cyc(0, 0, 1, 3000, 1);
        rst = 1'b1;
        cyc(1, 8, 1, 3000, 1);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            total++;
            if ({ov[k], od[k], oo[k], os[k], bz[k]} !== 20'd0) begin
                bad++;
                $display("FAIL rst_mid[%0d]: v=%b d=%0d ovf=%b sat=%b busy=%b, want all 0",
                         k, ov[k], od[k], oo[k], os[k], bz[k]);
            end
        end
        p0 = npulse;
        repeat (6) cyc(0, 0, 1, 3000, 1);
        total++;
        if ({npulse == p0, bz[0], od[0]} !== {1'b1, 1'b0, 16'sd0}) begin
            bad++;
            $display("FAIL rst_after: pulses=%0d busy=%b d=%0d want 0 0 0", npulse - p0, bz[0], od[0]);
        end
    endtask

    task automatic test_random();
        logic signed [15:0] ed;
        logic es;
        int n;
        for (int f = 0; f < 24; f++) begin
            n = $urandom_range((f % 4 == 0) ? 200 : 12, 1);
            q_data = {};
            q_ovf = {};
            for (int i = 0; i < n; i++) begin
                q_data.push_back(int'($urandom_range(65535, 0)) - 32768);
                q_ovf.push_back($urandom_range(15, 0) == 0);
            end
            run_frame(2, f[0]);
            for (int k = 0; k < 3; k++) begin
                model(shift_of(k), ed, es);
                total++;
                if ({r_early, r_v[k], r_d[k], r_ovf[k], r_sat[k], r_busy[k], r_v2[k], r_d2[k]} !==
                    {1'b0, 1'b1, ed, model_ovf(), es, 1'b0, 1'b0, ed}) begin
                    bad++;
                    $display("FAIL rand%0d[%0d]: early=%b v=%b d=%0d ovf=%b sat=%b busy=%b v2=%b want d=%0d ovf=%b sat=%b",
                             f, k, r_early, r_v[k], r_d[k], r_ovf[k], r_sat[k], r_busy[k], r_v2[k],
                             ed, model_ovf(), es);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gaps_ovf();
        test_rounding();
        test_abort();
        test_idle();
        test_saturation();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
